// File: rtl/inc_pkg.sv
// Shared constants and word type for the timer incrementer.
package inc_pkg;

  localparam int unsigned INC_WIDTH = 8;
  localparam logic [INC_WIDTH-1:0] INC_ALL_ONES = '1;

  typedef logic [INC_WIDTH-1:0] inc_word_t;

endpackage

// File: rtl/inc_half_adder.sv
// Single-bit half adder: one stage of the ripple incrementer chain.
module inc_half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/incrementor_8bit.sv
// Unsigned +1 incrementer: half-adder ripple result, registered copy and optional sticky
// wrap flag (enabled by defining INC8_OVF_STICKY_EN).
module incrementor_8bit
  import inc_pkg::*;
#(
  parameter int unsigned WIDTH = INC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic [WIDTH-1:0] out_q,
  output logic             carry_q,
  output logic             ovf_sticky
);

  // Carry lives inside each generate scope so the chain is not one self-feeding vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic b;
    logic c;
    if (i == 0) begin : g_lsb
      assign b = 1'b1;
    end else begin : g_rip
      assign b = g_bit[i-1].c;
    end
    inc_half_adder u_ha (
      .a(in[i]),
      .b(b),
      .s(out[i]),
      .c(c)
    );
  end

  assign carry_out = g_bit[WIDTH-1].c;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      out_q   <= out;
      carry_q <= carry_out;
    end
  end

`ifdef INC8_OVF_STICKY_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (carry_out) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_sticky = ovf_q;
`else
  assign ovf_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_incrementor_8bit.sv
// Self-checking bench for incrementor_8bit: vector table, exhaustive sweep, corner sequences
// and randomized traffic against an arithmetic reference model.
module tb_incrementor_8bit;

`ifdef INC8_OVF_STICKY_EN
  localparam bit StickyEn = 1'b1;
`else
  localparam bit StickyEn = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] in;
  logic [7:0] out;
  logic       carry_out;
  logic [7:0] out_q;
  logic       carry_q;
  logic       ovf_sticky;

  int total;
  int bad;

  // Reference model of the registered outputs.
  logic [7:0] exp_out_q;
  logic       exp_carry_q;
  logic       exp_ovf;

  typedef struct {
    logic [7:0] vin;
    logic [7:0] vout;
    logic       vcarry;
  } vec_t;

  vec_t vecs[8];

  incrementor_8bit #(
    .WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in(in),
    .out(out),
    .carry_out(carry_out),
    .out_q(out_q),
    .carry_q(carry_q),
    .ovf_sticky(ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Apply inputs, take one edge, advance the model and check all registered outputs.
  task automatic step(input logic rst_v, input logic [7:0] in_v);
    logic [8:0] sum;
    rst = rst_v;
    in  = in_v;
    #1;
    sum = {1'b0, in_v} + 9'd1;
    check8("comb_out", out, sum[7:0]);
    check1("comb_carry", carry_out, sum[8]);
    @(posedge clk);
    if (rst_v) begin
      exp_out_q   = 8'h00;
      exp_carry_q = 1'b0;
      exp_ovf     = 1'b0;
    end else begin
      exp_out_q   = sum[7:0];
      exp_carry_q = sum[8];
      exp_ovf     = exp_ovf | (StickyEn & sum[8]);
    end
    #1;
    check8("out_q", out_q, exp_out_q);
    check1("carry_q", carry_q, exp_carry_q);
    check1("ovf_sticky", ovf_sticky, exp_ovf);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    in    = 8'h00;
    exp_ovf = 1'b0;

    vecs[0] = '{8'h00, 8'h01, 1'b0};
    vecs[1] = '{8'h01, 8'h02, 1'b0};
    vecs[2] = '{8'h7F, 8'h80, 1'b0};
    vecs[3] = '{8'h80, 8'h81, 1'b0};
    vecs[4] = '{8'hFE, 8'hFF, 1'b0};
    vecs[5] = '{8'hFF, 8'h00, 1'b1};
    vecs[6] = '{8'h3C, 8'h3D, 1'b0};
    vecs[7] = '{8'h0F, 8'h10, 1'b0};

    // Reset state.
    @(posedge clk);
    #1;
    check8("reset_out_q", out_q, 8'h00);
    check1("reset_carry_q", carry_q, 1'b0);
    check1("reset_ovf", ovf_sticky, 1'b0);

    // Combinational table, with reset still held.
    for (int i = 0; i < 8; i++) begin
      in = vecs[i].vin;
      #1;
      check8("tbl_out", out, vecs[i].vout);
      check1("tbl_carry", carry_out, vecs[i].vcarry);
    end

    // Exhaustive sweep.
    for (int i = 0; i < 256; i++) begin
      in = 8'(i);
      #1;
      check8("sweep_out", out, 8'((i + 1) % 256));
      check1("sweep_carry", carry_out, i == 255);
    end

    // Align to a clean point after an edge with the model in reset state.
    step(1'b1, 8'h00);

    // 7F: no wrap.
    step(1'b0, 8'h7F);
    check8("seq7f_out_q", out_q, 8'h80);
    check1("seq7f_carry_q", carry_q, 1'b0);

    // FF: wrap, then sticky holds across a non-wrapping value.
    step(1'b0, 8'hFF);
    check8("seqff_out_q", out_q, 8'h00);
    check1("seqff_carry_q", carry_q, 1'b1);
    check1("seqff_ovf", ovf_sticky, StickyEn);
    step(1'b0, 8'h05);
    check1("seq05_ovf_hold", ovf_sticky, StickyEn);
    check8("seq05_out_q", out_q, 8'h06);
    step(1'b0, 8'h05);
    check1("seq05_ovf_hold2", ovf_sticky, StickyEn);

    // Reset with 3C: comb tracks input, registers clear, capture resumes next edge.
    step(1'b1, 8'h3C);
    check8("rst3c_out_q", out_q, 8'h00);
    check1("rst3c_carry_q", carry_q, 1'b0);
    check1("rst3c_ovf", ovf_sticky, 1'b0);
    step(1'b0, 8'h3C);
    check8("post_rst_out_q", out_q, 8'h3D);

    // Reset and wrap on the same edge: reset wins.
    step(1'b0, 8'hFF);
    step(1'b1, 8'hFF);
    check1("rst_wins_ovf", ovf_sticky, 1'b0);
    check1("rst_wins_carry_q", carry_q, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] v;
      logic       r;
      v = 8'($urandom);
      if ($urandom_range(0, 7) == 0) v = 8'hFF;
      r = ($urandom_range(0, 15) == 0);
      step(r, v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
